mem_stage_ctrl: RTL and testbench

- Sequences data-memory accesses for the instruction held in the EX/MEM pipeline register of the 5-stage RISC-V core.
- Detects a load or store in the M stage and runs a req/ready handshake with a variable-latency data memory.
- Stalls the pipeline until the access completes, then returns load data to the writeback path.

---
 rtl/mem_stage_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: M-stage data-memory access sequencer for the 5-stage core.
// A load or store sitting in EX/MEM is turned into a req/ready handshake
// with a variable-latency data memory. The pipeline is stalled until the
// access completes, and the load data is then handed to the writeback path.
//
// Optional build: define MEM_TIMEOUT_EN to abort a request that has waited
// TIMEOUT_CYCLES REQ cycles. The abort pulses mem_err for one cycle.
// Without the macro the controller waits in REQ indefinitely and mem_err is
// held at 0.
module mem_stage_ctrl #(
    parameter int word_width     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            ResultSrcM,
    input  logic                  MemWriteM,
    input  logic [word_width-1:0] ALUResultM,
    input  logic [word_width-1:0] WriteDataM,
    input  logic                  mem_ready,
    input  logic [word_width-1:0] mem_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [word_width-1:0] mem_addr,
    output logic [word_width-1:0] mem_wdata,
    output logic [word_width-1:0] ReadDataM,
    output logic                  StallMem,
    output logic                  mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t                state_reg, state_next;
    logic                  we_reg, we_next;
    logic [word_width-1:0] addr_reg, addr_next;
    logic [word_width-1:0] wdata_reg, wdata_next;
    logic [word_width-1:0] rdata_reg, rdata_next;
    logic                  stall_comb;
    logic                  access;
    logic                  timeout_hit;
    logic                  err_next;

    // A store wins when both store and load are flagged. mem_we takes
    // MemWriteM directly, so this falls out of the latch without extra logic.
    assign access = MemWriteM | (ResultSrcM == 2'b01);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             err_reg;

    // The counter holds the number of REQ cycles already spent. When the
    // current REQ cycle is the TIMEOUT_CYCLES-th one, the request is aborted
    // on this edge unless mem_ready arrives in the same cycle.
    assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count REQ cycles. The counter is cleared while idle, so it starts
    // from zero on every entry to REQ.
    always_comb begin
        cnt_next = cnt_reg;
        if (state_reg == REQ) begin
            cnt_next = cnt_reg + 1'b1;
        end else begin
            cnt_next = '0;
        end
    end

    // Register the REQ-cycle counter and the one-cycle error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            err_reg <= err_next;
        end
    end

    assign mem_err = err_reg;
`else
    // No timeout logic is built. The parameter is referenced only so that
    // it is not dangling; a non-negative value keeps this tie at 0.
    assign timeout_hit = 1'b0;
    assign mem_err     = (TIMEOUT_CYCLES < 0) ? 1'b1 : 1'b0;
`endif

    // Next-state, latch and stall decode for the IDLE -> REQ -> DONE sequence.
    always_comb begin
        state_next = state_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        stall_comb = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                // The stall is raised in the same cycle the access appears,
                // so the instruction stays in EX/MEM.
                stall_comb = access;
                if (access) begin
                    addr_next  = ALUResultM;
                    wdata_next = WriteDataM;
                    we_next    = MemWriteM;
                    state_next = REQ;
                end
            end
            REQ: begin
                stall_comb = 1'b1;
                if (mem_ready) begin
                    // Completion has priority over a timeout in the same cycle.
                    if (!we_reg) begin
                        rdata_next = mem_rdata;
                    end
                    state_next = DONE;
                end else if (timeout_hit) begin
                    if (!we_reg) begin
                        rdata_next = '0;
                    end
                    err_next   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                // The stall is released here so the pipeline advances on this
                // edge. The next access is only seen in IDLE.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Register the controller state, the latched request and the load data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
        end
    end

    // mem_req decodes the registered state only, so no input reaches it
    // combinationally.
    assign mem_req   = (state_reg == REQ);
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign ReadDataM = rdata_reg;
    assign StallMem  = stall_comb;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed scoreboard bench for mem_stage_ctrl.
// For each access, the expected load data, error flag and cycle counts are
// queued when the stimulus is driven. They are popped and compared in the
// DONE cycle.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] ReadDataM;
    logic        StallMem;
    logic        mem_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stalls;
        int          reqs;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rd;
    int          n_asserts = 0;
    int          n_fail    = 0;

    mem_stage_ctrl #(
        .word_width    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ResultSrcM(ResultSrcM),
        .MemWriteM (MemWriteM),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .ReadDataM (ReadDataM),
        .StallMem  (StallMem),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic bubble();
        ResultSrcM = 2'b00;
        MemWriteM  = 1'b0;
        ALUResultM = $urandom;
        WriteDataM = $urandom;
    endtask

    // Called at posedge+1 with the DUT in IDLE. The access spans req_cycles
    // REQ cycles. When give_ready is set, mem_ready is raised in the last
    // REQ cycle. Returns at posedge+1 of the cycle that follows DONE.
    task automatic do_access(input logic st, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int req_cycles, input logic give_ready,
                             input logic exp_err, input logic bubble_after);
        exp_t e;
        int   stalls;
        int   reqs;
        if (!st) model_rd = give_ready ? rdata : 32'h0;
        e.rdata  = model_rd;
        e.err    = exp_err;
        e.stalls = req_cycles + 1;
        e.reqs   = req_cycles;
        sb.push_back(e);
        ResultSrcM = st ? 2'b00 : 2'b01;
        MemWriteM  = st;
        ALUResultM = addr;
        WriteDataM = wdata;
        mem_ready  = 1'b0;
        stalls = 0;
        reqs   = 0;
        @(negedge clk);
        if (StallMem) stalls++;
        check("idle_req_low", {31'b0, mem_req}, 32'h0);
        for (int c = 1; c <= req_cycles; c++) begin
            @(posedge clk); #1;
            mem_ready = give_ready && (c == req_cycles);
            mem_rdata = mem_ready ? rdata : $urandom;
            @(negedge clk);
            if (StallMem) stalls++;
            if (mem_req) reqs++;
            check("req_addr", mem_addr, addr);
            check("req_wdata", mem_wdata, wdata);
            check("req_we", {31'b0, mem_we}, {31'b0, st});
            check("req_err_low", {31'b0, mem_err}, 32'h0);
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        @(negedge clk);
        e = sb.pop_front();
        check("done_req_low", {31'b0, mem_req}, 32'h0);
        check("done_stall_low", {31'b0, StallMem}, 32'h0);
        check("done_rdata", ReadDataM, e.rdata);
        check("done_err", {31'b0, mem_err}, {31'b0, e.err});
        check("stall_cycles", 32'(stalls), 32'(e.stalls));
        check("req_cycles", 32'(reqs), 32'(e.reqs));
        @(posedge clk); #1;
        if (bubble_after) begin
            bubble();
            @(negedge clk);
            check("after_rdata_hold", ReadDataM, model_rd);
            check("after_stall_low", {31'b0, StallMem}, 32'h0);
            check("after_err_low", {31'b0, mem_err}, 32'h0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        model_rd  = 32'h0;
        bubble();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_rdata", ReadDataM, 32'h0);
        check("rst_mem_err", {31'b0, mem_err}, 32'h0);
        check("rst_stall", {31'b0, StallMem}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Load first, so that the later reset has nonzero load data to clear.
        do_access(1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 1, 1'b1, 1'b0, 1'b1);

        // Reset asserted while the load at 0x100 is in REQ.
        ResultSrcM = 2'b01;
        MemWriteM  = 1'b0;
        ALUResultM = 32'h0000_0100;
        WriteDataM = 32'h0;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_req_high", {31'b0, mem_req}, 32'h1);
        #1;
        reset = 1'b1;
        bubble();
        model_rd = 32'h0;
        #1;
        check("arst_mem_req", {31'b0, mem_req}, 32'h0);
        check("arst_stall", {31'b0, StallMem}, 32'h0);
        check("arst_rdata", ReadDataM, 32'h0);
        check("arst_mem_addr", mem_addr, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Load with mem_ready in the first REQ cycle.
        do_access(1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1, 1'b1, 1'b0, 1'b1);
        // Store with three wait cycles. The load data must not change.
        do_access(1'b1, 32'h0000_0080, 32'h1234_5678, 32'h5A5A_5A5A, 4, 1'b1, 1'b0, 1'b1);
        // A load and a store back to back, each with immediate ready.
        do_access(1'b0, 32'h0000_0200, 32'h0, 32'h1111_2222, 1, 1'b1, 1'b0, 1'b0);
        do_access(1'b1, 32'h0000_0204, 32'h3333_4444, 32'h7777_8888, 1, 1'b1, 1'b0, 1'b1);

        // An idle bubble with a stray mem_ready.
        bubble();
        mem_ready = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_req_low", {31'b0, mem_req}, 32'h0);
            check("stray_stall_low", {31'b0, StallMem}, 32'h0);
            check("stray_rdata", ReadDataM, model_rd);
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;

`ifdef MEM_TIMEOUT_EN
        // Timeout abort after 4 REQ cycles, then completion in the 4th cycle.
        do_access(1'b0, 32'h0000_0300, 32'h0, 32'hABCD_0123, 4, 1'b0, 1'b1, 1'b1);
        do_access(1'b0, 32'h0000_0304, 32'h0, 32'h5555_AAAA, 4, 1'b1, 1'b0, 1'b1);
`endif

        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
